// File: rtl/jtcop_gfxarb_if.sv
// jtcop_gfxarb_if: client, SDRAM and status signals of the graphics ROM arbiter.
// slave is the arbiter's view; master is the view of the fetchers, SDRAM controller and status reader.
interface jtcop_gfxarb_if #(
  parameter int AW  = 18,
  parameter int SAW = 22,
  parameter int DW  = 32
);
  logic [3:0]     c_cs;
  logic [AW-1:0]  c_addr0, c_addr1, c_addr2, c_addr3;
  logic [DW-1:0]  c_data;
  logic [3:0]     c_ok;
  logic           sdram_cs;
  logic [SAW-1:0] sdram_addr;
  logic [DW-1:0]  sdram_data;
  logic           sdram_ok;
  logic [2:0]     st_addr;
  logic [7:0]     st_dout;
  modport slave (
    input  c_cs, c_addr0, c_addr1, c_addr2, c_addr3, sdram_data, sdram_ok, st_addr,
    output c_data, c_ok, sdram_cs, sdram_addr, st_dout
  );
  modport master (
    output c_cs, c_addr0, c_addr1, c_addr2, c_addr3, sdram_data, sdram_ok, st_addr,
    input  c_data, c_ok, sdram_cs, sdram_addr, st_dout
  );
endinterface

// File: rtl/jtcop_gfxarb.sv
// jtcop_gfxarb: round-robin SDRAM read arbiter for four graphics ROM clients, each with a one-entry cache.
// Define JTCOP_GFXARB_STATS_EN to add per-client grant counters readable at st_addr 4..7.
module jtcop_gfxarb #(
  parameter int             AW   = 18,
  parameter int             SAW  = 22,
  parameter int             DW   = 32,
  parameter logic [SAW-1:0] OFF0 = '0,
  parameter logic [SAW-1:0] OFF1 = '0,
  parameter logic [SAW-1:0] OFF2 = '0,
  parameter logic [SAW-1:0] OFF3 = '0,
  parameter int             TOUT = 63
) (
  input  logic clk,
  input  logic rst_n,
  jtcop_gfxarb_if.slave bus
);
  typedef enum logic [2:0] {IDLE = 3'b001, WAIT = 3'b010, DONE = 3'b100} state_t;
  localparam int TW = $clog2(TOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TOUT - 1);
  localparam logic [3:0][SAW-1:0] OFFS = {OFF3, OFF2, OFF1, OFF0};
  state_t              state_q, state_d;
  logic [1:0]          ptr_q, ptr_d, id_q, id_d, g;
  logic [AW-1:0]       addr_q, addr_d;
  logic                sdram_cs_q, sdram_cs_d;
  logic [SAW-1:0]      sdram_addr_q, sdram_addr_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic [7:0]          tout_q, tout_d, st_dout_q, st_dout_d, stat;
  logic [3:0]          valid_q, valid_d, ok_q, ok_d, miss;
  logic [3:0][AW-1:0]  tag_q, tag_d, ca;
  logic [3:0][DW-1:0]  data_q, data_d;
  logic [DW-1:0]       c_data_q, c_data_d;
  assign ca = {bus.c_addr3, bus.c_addr2, bus.c_addr1, bus.c_addr0};
  // Lookup, circular priority search from the pointer, and the lowest-index data mux
  always_comb begin
    ok_d = '0;
    for (int i = 0; i < 4; i++) ok_d[i] = bus.c_cs[i] && valid_q[i] && tag_q[i] == ca[i];
    miss = bus.c_cs & ~ok_d;
    g = ptr_q;
    for (int j = 3; j >= 0; j--) if (miss[ptr_q + 2'(j)]) g = ptr_q + 2'(j);
    c_data_d = c_data_q;
    for (int i = 3; i >= 0; i--) if (ok_d[i]) c_data_d = data_q[i];
  end
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    addr_d       = addr_q;
    sdram_cs_d   = sdram_cs_q;
    sdram_addr_d = sdram_addr_q;
    tcnt_d       = tcnt_q;
    tout_d       = tout_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    data_d       = data_q;
    case (state_q)
      IDLE: if (|miss) begin
        state_d      = WAIT;
        sdram_cs_d   = 1'b1;
        sdram_addr_d = OFFS[g] + SAW'(ca[g]);
        id_d         = g;
        addr_d       = ca[g];
        ptr_d        = g + 2'd1;
        tcnt_d       = '0;
      end
      WAIT: if (bus.sdram_ok) begin
        valid_d[id_q] = 1'b1;
        tag_d[id_q]   = addr_q;
        data_d[id_q]  = bus.sdram_data;
        sdram_cs_d    = 1'b0;
        state_d       = DONE;
      end else if (tcnt_q == TLAST) begin
        sdram_cs_d = 1'b0;
        state_d    = DONE;
        tout_d     = tout_q + {7'd0, tout_q != 8'hff};
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    st_dout_d = bus.st_addr == 3'd0 ? {5'd0, state_q} :
                bus.st_addr == 3'd1 ? {6'd0, ptr_q} :
                bus.st_addr == 3'd2 ? tout_q : stat;
  end
`ifdef JTCOP_GFXARB_STATS_EN
  logic [3:0][7:0] gcnt_q, gcnt_d;
  always_comb begin
    gcnt_d = gcnt_q;
    if (state_q == IDLE && |miss) gcnt_d[g] = gcnt_q[g] + 8'd1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) gcnt_q <= '0;
    else gcnt_q <= gcnt_d;
  assign stat = bus.st_addr[2] ? gcnt_q[bus.st_addr[1:0]] : 8'hff;
`else
  assign stat = 8'hff;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      id_q         <= '0;
      addr_q       <= '0;
      sdram_cs_q   <= 1'b0;
      sdram_addr_q <= '0;
      tcnt_q       <= '0;
      tout_q       <= '0;
      valid_q      <= '0;
      tag_q        <= '0;
      data_q       <= '0;
      ok_q         <= '0;
      c_data_q     <= '0;
      st_dout_q    <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      addr_q       <= addr_d;
      sdram_cs_q   <= sdram_cs_d;
      sdram_addr_q <= sdram_addr_d;
      tcnt_q       <= tcnt_d;
      tout_q       <= tout_d;
      valid_q      <= valid_d;
      tag_q        <= tag_d;
      data_q       <= data_d;
      ok_q         <= ok_d;
      c_data_q     <= c_data_d;
      st_dout_q    <= st_dout_d;
    end
  end
  assign bus.c_data     = c_data_q;
  assign bus.c_ok       = ok_q;
  assign bus.sdram_cs   = sdram_cs_q;
  assign bus.sdram_addr = sdram_addr_q;
  assign bus.st_dout    = st_dout_q;
endmodule

// File: tb/tb_jtcop_gfxarb.sv
// tb_jtcop_gfxarb: scenario tasks against a transaction-level model of the arbiter (cache tags, pointer, timeouts).
// An SDRAM responder logs every request and answers with a fixed function of the address.
module tb_jtcop_gfxarb;
  localparam logic [21:0] OFF0 = 22'h100000, OFF1 = 22'h080000, OFF2 = 22'h200000, OFF3 = 22'h3fff00;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  jtcop_gfxarb_if #(.AW(18), .SAW(22), .DW(32)) bus();
  jtcop_gfxarb #(.AW(18), .SAW(22), .DW(32), .OFF0(OFF0), .OFF1(OFF1), .OFF2(OFF2), .OFF3(OFF3), .TOUT(63))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_chk = 0, n_fail = 0;
  logic [21:0] req_q[$];
  int lat = 0;
  bit mute = 0;
  int exp_ptr = 0, exp_tout = 0;
  bit exp_valid[4];
  logic [17:0] exp_tag[4];
  function automatic logic [31:0] mem(input logic [21:0] a);
    return a == 22'h080123 ? 32'hcafebabe : {a[9:0], a} ^ 32'ha5a50f0f;
  endfunction
  function automatic logic [21:0] sa(input int c, input logic [17:0] a);
    logic [21:0] o;
    o = c == 0 ? OFF0 : c == 1 ? OFF1 : c == 2 ? OFF2 : OFF3;
    return o + {4'd0, a};
  endfunction
  initial begin : responder
    int cnt;
    bit busy;
    logic [21:0] cur;
    busy = 0; cnt = 0; cur = '0;
    bus.sdram_ok = 1'b0;
    bus.sdram_data = '0;
    forever begin
      @(negedge clk);
      bus.sdram_ok = 1'b0;
      if (!rst_n || !bus.sdram_cs) busy = 0;
      else begin
        if (!busy) begin busy = 1; cur = bus.sdram_addr; req_q.push_back(cur); cnt = lat; end
        if (cnt == 0) begin
          if (!mute) begin bus.sdram_ok = 1'b1; bus.sdram_data = mem(cur); end
        end else cnt--;
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic tick(input int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask
  task automatic put(input int c, input bit cs, input logic [17:0] a);
    case (c)
      0: bus.c_addr0 = a;
      1: bus.c_addr1 = a;
      2: bus.c_addr2 = a;
      default: bus.c_addr3 = a;
    endcase
    bus.c_cs[c] = cs;
  endtask
  task automatic wait_req(output logic [21:0] a);
    a = 'x;
    for (int i = 0; i < 300 && req_q.size() == 0; i++) tick();
    if (req_q.size() != 0) a = req_q.pop_front();
  endtask
  task automatic wait_ok(input int c);
    for (int i = 0; i < 300 && !bus.c_ok[c]; i++) tick();
  endtask
  task automatic idle();
    bus.c_cs = 4'h0;
    tick(4);
    req_q.delete();
  endtask
  task automatic model_reset();
    exp_ptr = 0; exp_tout = 0;
    for (int i = 0; i < 4; i++) exp_valid[i] = 0;
  endtask
  task automatic test_reset();
    bus.c_cs = 4'h0; bus.c_addr0 = '0; bus.c_addr1 = '0; bus.c_addr2 = '0; bus.c_addr3 = '0; bus.st_addr = 3'd0;
    rst_n = 1'b0;
    tick(2);
    n_chk++; if (bus.sdram_cs !== 1'b0) begin n_fail++; $display("FAIL reset_sdram_cs: got %b want 0", bus.sdram_cs); end
    n_chk++; if (bus.sdram_addr !== 22'h0) begin n_fail++; $display("FAIL reset_sdram_addr: got %h want 0", bus.sdram_addr); end
    n_chk++; if (bus.c_ok !== 4'h0) begin n_fail++; $display("FAIL reset_c_ok: got %b want 0000", bus.c_ok); end
    n_chk++; if (bus.c_data !== 32'h0) begin n_fail++; $display("FAIL reset_c_data: got %h want 0", bus.c_data); end
    n_chk++; if (bus.st_dout !== 8'h0) begin n_fail++; $display("FAIL reset_st_dout: got %h want 00", bus.st_dout); end
    rst_n = 1'b1;
    model_reset();
    tick(2);
    n_chk++; if (bus.st_dout !== 8'h01) begin n_fail++; $display("FAIL reset_state_idle: got %h want 01", bus.st_dout); end
  endtask
  task automatic test_single_miss();
    logic [21:0] a;
    time t0;
    idle();
    lat = 5;
    t0 = $time;
    put(1, 1, 18'h00123);
    wait_req(a);
    n_chk++; if (a !== 22'h080123) begin n_fail++; $display("FAIL single_addr: got %h want 080123", a); end
    wait_ok(1);
    n_chk++; if (($time - t0) / 10 != 8) begin n_fail++; $display("FAIL single_latency: got %0d want 8 cycles", ($time - t0) / 10); end
    n_chk++; if (bus.c_data !== 32'hcafebabe) begin n_fail++; $display("FAIL single_data: got %h want cafebabe", bus.c_data); end
    exp_ptr = 2; exp_valid[1] = 1; exp_tag[1] = 18'h00123;
    tick(5);
    n_chk++; if (bus.c_ok !== 4'b0010 || bus.sdram_cs !== 1'b0 || req_q.size() != 0)
      begin n_fail++; $display("FAIL single_hold_hit: got ok=%b cs=%b reqs=%0d want ok=0010 cs=0 reqs=0", bus.c_ok, bus.sdram_cs, req_q.size()); end
    bus.st_addr = 3'd1;
    tick();
    n_chk++; if (bus.st_dout !== 8'(exp_ptr)) begin n_fail++; $display("FAIL single_pointer: got %h want %0d", bus.st_dout, exp_ptr); end
    bus.st_addr = 3'd0;
  endtask
  task automatic test_round_robin();
    logic [17:0] ra[4];
    bit pend[4];
    logic [21:0] a;
    int g;
    idle();
    lat = $urandom_range(0, 6);
    for (int i = 0; i < 4; i++) begin
      ra[i] = 18'($urandom);
      if (exp_valid[i] && ra[i] == exp_tag[i]) ra[i] ^= 18'h1;
      pend[i] = 1;
      put(i, 1, ra[i]);
    end
    for (int k = 0; k < 4; k++) begin
      g = exp_ptr;
      while (!pend[g]) g = (g + 1) % 4;
      wait_req(a);
      n_chk++; if (a !== sa(g, ra[g])) begin n_fail++; $display("FAIL rr_grant%0d: got %h want %h (client %0d)", k, a, sa(g, ra[g]), g); end
      pend[g] = 0; exp_ptr = (g + 1) % 4; exp_valid[g] = 1; exp_tag[g] = ra[g];
    end
    for (int i = 0; i < 300 && bus.c_ok !== 4'hf; i++) tick();
    n_chk++; if (bus.c_ok !== 4'hf) begin n_fail++; $display("FAIL rr_all_ok: got %b want 1111", bus.c_ok); end
    n_chk++; if (bus.c_data !== mem(sa(0, ra[0]))) begin n_fail++; $display("FAIL rr_data_mux: got %h want %h", bus.c_data, mem(sa(0, ra[0]))); end
    tick(3);
    n_chk++; if (bus.st_dout !== 8'h01 || req_q.size() != 0) begin n_fail++; $display("FAIL rr_settle: got st=%h reqs=%0d want st=01 reqs=0", bus.st_dout, req_q.size()); end
  endtask
  task automatic test_addr_change();
    logic [21:0] a;
    idle();
    lat = $urandom_range(0, 4);
    put(1, 1, exp_tag[1]);
    put(0, 1, 18'h10);
    wait_req(a);
    n_chk++; if (a !== sa(0, 18'h10)) begin n_fail++; $display("FAIL chg_first_addr: got %h want %h", a, sa(0, 18'h10)); end
    wait_ok(0);
    n_chk++; if (bus.c_ok !== 4'b0011 || bus.c_data !== mem(sa(0, 18'h10)))
      begin n_fail++; $display("FAIL chg_first_ok: got ok=%b data=%h want ok=0011 data=%h", bus.c_ok, bus.c_data, mem(sa(0, 18'h10))); end
    put(0, 1, 18'h11);
    tick();
    n_chk++; if (bus.c_ok !== 4'b0010) begin n_fail++; $display("FAIL chg_ok_drop: got %b want 0010", bus.c_ok); end
    wait_req(a);
    n_chk++; if (a !== sa(0, 18'h11)) begin n_fail++; $display("FAIL chg_second_addr: got %h want %h", a, sa(0, 18'h11)); end
    wait_ok(0);
    n_chk++; if (bus.c_data !== mem(sa(0, 18'h11))) begin n_fail++; $display("FAIL chg_second_data: got %h want %h", bus.c_data, mem(sa(0, 18'h11))); end
    exp_ptr = 1; exp_valid[0] = 1; exp_tag[0] = 18'h11;
    bus.c_cs = 4'h0;
    tick();
    n_chk++; if (bus.c_ok !== 4'h0) begin n_fail++; $display("FAIL chg_cs_drop: got %b want 0000", bus.c_ok); end
  endtask
  task automatic test_timeout();
    logic [21:0] a;
    logic [17:0] ad;
    int n;
    idle();
    ad = 18'($urandom);
    if (exp_valid[3] && ad == exp_tag[3]) ad ^= 18'h1;
    mute = 1;
    bus.st_addr = 3'd0;
    put(3, 1, ad);
    wait_req(a);
    n_chk++; if (a !== sa(3, ad)) begin n_fail++; $display("FAIL tout_addr: got %h want %h", a, sa(3, ad)); end
    n = 0;
    while (bus.sdram_cs && n < 200) begin
      n++;
      if (n == 10) begin
        n_chk++; if (bus.st_dout !== 8'h02) begin n_fail++; $display("FAIL tout_state_wait: got %h want 02", bus.st_dout); end
      end
      tick();
    end
    n_chk++; if (n != 63) begin n_fail++; $display("FAIL tout_cycles: got %0d want 63", n); end
    exp_tout++;
    bus.st_addr = 3'd2;
    tick();
    n_chk++; if (bus.st_dout !== 8'(exp_tout)) begin n_fail++; $display("FAIL tout_count: got %h want %0d", bus.st_dout, exp_tout); end
    wait_req(a);
    mute = 0;
    n_chk++; if (a !== sa(3, ad)) begin n_fail++; $display("FAIL tout_regrant: got %h want %h", a, sa(3, ad)); end
    wait_ok(3);
    n_chk++; if (bus.c_ok[3] !== 1'b1 || bus.c_data !== mem(sa(3, ad)))
      begin n_fail++; $display("FAIL tout_retry_data: got ok=%b data=%h want ok=1 data=%h", bus.c_ok[3], bus.c_data, mem(sa(3, ad))); end
    exp_ptr = 0; exp_valid[3] = 1; exp_tag[3] = ad;
    bus.st_addr = 3'd0;
  endtask
  task automatic test_reset_midwait();
    logic [21:0] a;
    logic [17:0] ad;
    idle();
    ad = 18'($urandom);
    if (exp_valid[2] && ad == exp_tag[2]) ad ^= 18'h1;
    put(1, 1, exp_tag[1]);
    mute = 1;
    put(2, 1, ad);
    wait_req(a);
    n_chk++; if (a !== sa(2, ad)) begin n_fail++; $display("FAIL rstw_addr: got %h want %h", a, sa(2, ad)); end
    tick(3);
    n_chk++; if (bus.sdram_cs !== 1'b1 || bus.c_ok !== 4'b0010)
      begin n_fail++; $display("FAIL rstw_pre: got cs=%b ok=%b want cs=1 ok=0010", bus.sdram_cs, bus.c_ok); end
    rst_n = 1'b0;
    #1;
    n_chk++; if (bus.sdram_cs !== 1'b0 || bus.c_ok !== 4'h0 || bus.sdram_addr !== 22'h0)
      begin n_fail++; $display("FAIL rstw_async: got cs=%b ok=%b addr=%h want 0/0000/0", bus.sdram_cs, bus.c_ok, bus.sdram_addr); end
    tick();
    req_q.delete();
    mute = 0;
    model_reset();
    rst_n = 1'b1;
    wait_req(a);
    n_chk++; if (a !== sa(1, exp_tag[1])) begin n_fail++; $display("FAIL rstw_first: got %h want %h", a, sa(1, exp_tag[1])); end
    wait_req(a);
    n_chk++; if (a !== sa(2, ad)) begin n_fail++; $display("FAIL rstw_second: got %h want %h", a, sa(2, ad)); end
    exp_ptr = 3; exp_valid[1] = 1; exp_valid[2] = 1; exp_tag[2] = ad;
    wait_ok(2);
    bus.st_addr = 3'd2;
    tick();
    n_chk++; if (bus.c_ok !== 4'b0110 || bus.st_dout !== 8'h00)
      begin n_fail++; $display("FAIL rstw_after: got ok=%b tout=%h want ok=0110 tout=00", bus.c_ok, bus.st_dout); end
    bus.st_addr = 3'd0;
  endtask
  task automatic test_stats();
    logic [21:0] a;
    logic [17:0] base;
    logic [7:0] want;
    bus.c_cs = 4'h0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    idle();
    base = 18'($urandom);
    for (int k = 0; k < 3; k++) begin
      put(3, 1, base + 18'(k));
      wait_req(a);
      n_chk++; if (a !== sa(3, base + 18'(k))) begin n_fail++; $display("FAIL stats_req%0d: got %h want %h", k, a, sa(3, base + 18'(k))); end
      wait_ok(3);
    end
    exp_ptr = 0;
`ifdef JTCOP_GFXARB_STATS_EN
    want = 8'd3;
`else
    want = 8'hff;
`endif
    bus.st_addr = 3'd7;
    tick();
    n_chk++; if (bus.st_dout !== want) begin n_fail++; $display("FAIL stats_client3: got %h want %h", bus.st_dout, want); end
    bus.st_addr = 3'd4;
    tick();
    n_chk++; if (bus.st_dout !== (want == 8'hff ? 8'hff : 8'h00)) begin n_fail++; $display("FAIL stats_client0: got %h", bus.st_dout); end
    bus.st_addr = 3'd3;
    tick();
    n_chk++; if (bus.st_dout !== 8'hff) begin n_fail++; $display("FAIL stats_addr3: got %h want ff", bus.st_dout); end
    bus.st_addr = 3'd1;
    tick();
    n_chk++; if (bus.st_dout !== 8'(exp_ptr)) begin n_fail++; $display("FAIL stats_ptr_wrap: got %h want %0d", bus.st_dout, exp_ptr); end
  endtask
  initial begin
    test_reset();
    test_single_miss();
    test_round_robin();
    test_addr_change();
    test_timeout();
    test_reset_midwait();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/jtcop_gfxarb.md
Name: jtcop_gfxarb

Overview:
- Round-robin arbiter sharing one SDRAM read slot among the four graphics ROM requesters of the video section: foreground, background, character tile ROMs and the object ROM.
- Sits between those layer/object fetchers and the SDRAM controller.
- Each client sees a private cs/addr/data/ok port backed by a one-entry cache.
- A region offset is added per client to form the SDRAM word address.

Parameters:
- AW, 18, client word-address width.
- SAW, 22, SDRAM word-address width.
- DW, 32, data width.
- OFF0..OFF3, 22'h0, SDRAM base offset for clients 0..3 (0=ba0, 1=ba1, 2=ba2, 3=obj).
- TOUT, 63, max wait cycles for sdram_ok before the request is abandoned.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- c_cs  in  4  per-client request, bit i = client i
- c_addr0..c_addr3  in  AW each  client addresses
- c_data  out  DW  shared registered read data, valid for client i while c_ok[i]=1
- c_ok  out  4  per-client data valid
- sdram_cs  out  1  request to SDRAM controller
- sdram_addr  out  SAW  request address
- sdram_data  in  DW  SDRAM read data
- sdram_ok  in  1  SDRAM data valid
- st_addr  in  3  status select
- st_dout  out  8  status read-back

Behaviour:
Reset (async, rst_n=0):
- sdram_cs=0, sdram_addr=0, c_ok=0, c_data=0, st_dout=0.
- All cache-valid bits cleared; round-robin pointer=0; state=IDLE.

Cache:
- One entry per client: tag (AW bits), valid bit, data.
- Hit: c_cs[i]=1, valid[i]=1 and tag[i]==c_addr_i.
- c_ok[i] is registered: high the cycle after a hit is seen, otherwise low.
- c_ok[i] drops one cycle after cs falls or the address changes.
- c_data is muxed from the cache of the lowest-index client with c_ok set. Clients must not rely on c_data when another client's ok is also high; the fetchers time-multiplex by design.

State machine:
- IDLE
  - Misses are c_cs[i]=1 and not a hit.
  - If any miss: grant the first miss at or after the pointer, circularly; latch client id and address.
  - Drive sdram_cs=1 and sdram_addr = OFFi + zero-extended c_addr_i (modulo 2^SAW), then go to WAIT.
  - Pointer advances to granted id+1 (wraps 3->0).
- WAIT
  - sdram_cs held at 1 and sdram_addr held stable.
  - On sdram_ok=1: write the latched tag and data into cache[id], set valid, deassert sdram_cs, go to DONE.
  - Data is stored against the latched address even if the client moved away meanwhile.
  - The timeout counter increments each cycle. At TOUT: sdram_cs=0, no cache write, go to DONE (client retries naturally as a miss). Increment the timeout status counter.
- DONE
  - One bubble cycle with sdram_cs=0, then IDLE.
  - Guarantees the controller sees cs low between requests.

Latency and fairness:
- Best-case miss-to-ok is 3 cycles plus SDRAM latency.
- No client waits more than 3 other grants.

Boundary cases:
- Simultaneous misses on all four: grant order follows the pointer.
- A requester dropping cs during WAIT does not cancel the transfer.
- A cache hit on one client never blocks arbitration for others.
- sdram_ok in IDLE/DONE is ignored.
- Status reads: st_addr 0 gives the state (one-hot IDLE=1, WAIT=2, DONE=4); 1 gives the pointer; 2 gives the timeout counter, 8-bit saturating.
- st_dout is registered.

Optional Feature:
- JTCOP_GFXARB_STATS_EN: when defined, per-client 8-bit wrapping grant counters, incremented on each IDLE->WAIT grant and cleared on reset.
- st_addr 4..7 return the counters for clients 0..3.
- Without the macro, st_addr 3..7 return 8'hff and the counters are not instantiated.

Test Plan:
- Reset: hold rst_n=0 mid-WAIT with sdram_cs=1 -> sdram_cs=0, c_ok=0 immediately; after release, the first miss is re-requested from scratch.
- Single miss: client 1 addr 18'h00123, OFF1=22'h080000, SDRAM replies after 5 cycles with 32'hCAFEBABE.
  - Expect sdram_addr=22'h080123.
  - Expect c_ok[1]=1 one cycle after the cache write, with c_data=32'hCAFEBABE.
  - Same address next cycle stays a hit with no sdram_cs.
- Round-robin: all four miss together with pointer=2 -> grant order 2,3,0,1, each separated by a DONE cycle with sdram_cs=0.
- Address change: client 0 ok on 18'h10, then addr becomes 18'h11 -> c_ok[0] low next cycle and a new request is issued for OFF0+18'h11.
- Timeout: TOUT=63, sdram_ok never asserted -> sdram_cs drops after 63 WAIT cycles, st_addr=2 reads 1, and the same client is re-granted.
- STATS_EN: 3 grants to client 3 -> st_addr=7 reads 8'd3; without the macro it reads 8'hff.
